// File: rtl/init_read_responder.sv
// Memory-side responder for the multi-slot init_read interface: round-robin grant,
// then streams words from a preloadable memory with a per-slot valid/ready handshake.
module init_read_responder #(
  parameter int C_NUM_RD_ID = 4,
  parameter int C_ID_WTH    = 4,
  parameter int C_ADDR_WTH  = 10,
  parameter int C_LEN_WTH   = 16,
  parameter int C_DATA_WTH  = 512
) (
  input  logic                              clk_intf,
  input  logic                              rst,
  input  logic [C_NUM_RD_ID-1:0]            init_read_req,
  input  logic [C_NUM_RD_ID*C_ID_WTH-1:0]   init_read_req_id,
  input  logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] init_read_addr,
  input  logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  init_read_len,
  output logic [C_NUM_RD_ID-1:0]            init_read_req_ack,
  output logic [C_NUM_RD_ID-1:0]            init_read_in_prog,
  output logic [C_DATA_WTH-1:0]             init_read_data,
  output logic [C_NUM_RD_ID-1:0]            init_read_data_vld,
  input  logic [C_NUM_RD_ID-1:0]            init_read_data_rdy,
  output logic [C_NUM_RD_ID-1:0]            init_read_cmpl,
  output logic [C_ID_WTH-1:0]               rsp_cur_id,
  input  logic                              mem_wr_en,
  input  logic [C_ADDR_WTH-1:0]             mem_wr_addr,
  input  logic [C_DATA_WTH-1:0]             mem_wr_data
);

  localparam int PW    = (C_NUM_RD_ID > 1) ? $clog2(C_NUM_RD_ID) : 1;
  localparam int DEPTH = 1 << C_ADDR_WTH;

  typedef enum logic [1:0] {IDLE, ACK, STREAM, CMPL} state_t;

  state_t                  state_q;
  logic [PW-1:0]           rr_ptr_q;
  logic [PW-1:0]           gnt_q;
  logic [C_ID_WTH-1:0]     id_q;
  logic [C_ADDR_WTH-1:0]   addr_q;
  logic [C_LEN_WTH-1:0]    cnt_q;
  logic [C_NUM_RD_ID-1:0]  ack_q;
  logic [C_NUM_RD_ID-1:0]  in_prog_q;
  logic [C_NUM_RD_ID-1:0]  vld_q;
  logic [C_NUM_RD_ID-1:0]  cmpl_q;
  logic [C_DATA_WTH-1:0]   data_q;

  logic [C_DATA_WTH-1:0]   mem [DEPTH];
  logic [C_DATA_WTH-1:0]   rd_word;
  logic                    gnt_found_d;
  logic [PW-1:0]           gnt_d;
  logic [C_NUM_RD_ID-1:0]  gnt_oh_d;
  logic [C_NUM_RD_ID-1:0]  slot_oh;
  logic                    beat_xfer;

  // NOTE: the memory has no reset branch, so preloaded contents survive rst.
  always_ff @(posedge clk_intf) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  // Combinational read; a same-cycle preload write lands after capture, so the old word is taken.
  assign rd_word = mem[addr_q];

  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    gnt_found_d = 1'b0;
    gnt_d       = '0;
    for (int i = 0; i < C_NUM_RD_ID; i++) begin
      if (!gnt_found_d && init_read_req[(int'(rr_ptr_q) + i) % C_NUM_RD_ID]) begin
        gnt_found_d = 1'b1;
        gnt_d       = PW'((int'(rr_ptr_q) + i) % C_NUM_RD_ID);
      end
    end
  end

  assign gnt_oh_d  = C_NUM_RD_ID'(1) << gnt_d;
  assign slot_oh   = C_NUM_RD_ID'(1) << gnt_q;
  // vld is one-hot on the granted slot, so ready on any other slot cannot cause a beat.
  assign beat_xfer = |(vld_q & init_read_data_rdy);

  // NOTE: all state below uses non-blocking assignments so every register updates on the same edge.
  always_ff @(posedge clk_intf or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      in_prog_q <= '0;
      vld_q     <= '0;
      cmpl_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found_d) begin
            gnt_q     <= gnt_d;
            id_q      <= init_read_req_id[gnt_d*C_ID_WTH +: C_ID_WTH];
            addr_q    <= init_read_addr[gnt_d*C_ADDR_WTH +: C_ADDR_WTH];
            cnt_q     <= init_read_len[gnt_d*C_LEN_WTH +: C_LEN_WTH];
            ack_q     <= gnt_oh_d;
            in_prog_q <= gnt_oh_d;
            state_q   <= ACK;
          end
        end
        ACK: begin
          ack_q <= '0;
          if (cnt_q == '0) begin
            cmpl_q  <= slot_oh;
            state_q <= CMPL;
          end else begin
            // cnt_q counts the beats still to load after the one presented now.
            data_q  <= rd_word;
            vld_q   <= slot_oh;
            addr_q  <= addr_q + 1'b1;
            cnt_q   <= cnt_q - 1'b1;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (beat_xfer) begin
            if (cnt_q == '0) begin
              vld_q   <= '0;
              cmpl_q  <= slot_oh;
              state_q <= CMPL;
            end else begin
              data_q <= rd_word;
              addr_q <= addr_q + 1'b1;
              cnt_q  <= cnt_q - 1'b1;
            end
          end
        end
        CMPL: begin
          cmpl_q    <= '0;
          in_prog_q <= '0;
          rr_ptr_q  <= (int'(gnt_q) == C_NUM_RD_ID - 1) ? '0 : gnt_q + 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign init_read_req_ack  = ack_q;
  assign init_read_in_prog  = in_prog_q;
  assign init_read_data     = data_q;
  assign init_read_data_vld = vld_q;
  assign init_read_cmpl     = cmpl_q;
  assign rsp_cur_id         = id_q;

endmodule

// File: tb/tb_init_read_responder.sv
// Directed bench for init_read_responder: reset, single read, backpressure,
// round-robin, address wrap, zero length, reset mid-stream and write collision.
module tb_init_read_responder;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int DW = 512;
  localparam logic [N-1:0]  NONE     = '0;
  localparam logic [DW-1:0] NEW_WORD = {16{32'hCAFE_F00D}};

  logic            clk_intf = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*IW-1:0] req_id;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    ack;
  logic [N-1:0]    in_prog;
  logic [DW-1:0]   data;
  logic [N-1:0]    vld;
  logic [N-1:0]    rdy;
  logic [N-1:0]    cmpl;
  logic [IW-1:0]   cur_id;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_wr_addr;
  logic [DW-1:0]   mem_wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_intf = ~clk_intf;

  init_read_responder #(
    .C_NUM_RD_ID(N), .C_ID_WTH(IW), .C_ADDR_WTH(AW), .C_LEN_WTH(LW), .C_DATA_WTH(DW)
  ) dut (
    .clk_intf           (clk_intf),
    .rst                (rst),
    .init_read_req      (req),
    .init_read_req_id   (req_id),
    .init_read_addr     (req_addr),
    .init_read_len      (req_len),
    .init_read_req_ack  (ack),
    .init_read_in_prog  (in_prog),
    .init_read_data     (data),
    .init_read_data_vld (vld),
    .init_read_data_rdy (rdy),
    .init_read_cmpl     (cmpl),
    .rsp_cur_id         (cur_id),
    .mem_wr_en          (mem_wr_en),
    .mem_wr_addr        (mem_wr_addr),
    .mem_wr_data        (mem_wr_data)
  );

  // Expected {ack, vld, in_prog, cmpl} in cycle c of a request (cycle 0 = IDLE sample).
  function automatic logic [4*N-1:0] ctrl_exp(input int c, input int v_lo, input int v_hi,
                                              input int cm_c, input logic [N-1:0] oh);
    ctrl_exp = {(c == 1) ? oh : NONE,
                (c >= v_lo && c <= v_hi) ? oh : NONE,
                (c >= 1 && c <= cm_c) ? oh : NONE,
                (c == cm_c) ? oh : NONE};
  endfunction

  task automatic set_slot(input int s, input logic [IW-1:0] id, input logic [AW-1:0] a,
                          input logic [LW-1:0] l);
    req_id[s*IW +: IW]   = id;
    req_addr[s*AW +: AW] = a;
    req_len[s*LW +: LW]  = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rdy = '1; req_id = '0; req_addr = '0; req_len = '0;
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    repeat (2) @(negedge clk_intf);
    checks++;
    if ({ack, in_prog, vld, cmpl, data, cur_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b ip=%b vld=%b cmpl=%b id=%h, want all 0",
               ack, in_prog, vld, cmpl, cur_id);
    end
    rst = 1'b0;
    @(negedge clk_intf);
    checks++;
    if ({ack, in_prog, vld, cmpl} !== '0) begin
      errors++;
      $display("FAIL reset_idle got %h want 0", {ack, in_prog, vld, cmpl});
    end
  endtask

  task automatic preload();
    for (int k = 0; k < (1 << AW); k++) begin
      mem_wr_en = 1'b1; mem_wr_addr = AW'(k); mem_wr_data = DW'(k);
      @(negedge clk_intf);
    end
    mem_wr_en = 1'b0;
  endtask

  task automatic test_single_read();
    logic [4*N-1:0] e;
    set_slot(0, 4'hA, 10'd5, 16'd4);
    rdy = '1;
    @(negedge clk_intf);
    req[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 2, 5, 6, 4'b0001);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL single_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (data !== DW'(5 + c - 2)) begin
          errors++;
          $display("FAIL single_data c%0d got %0d want %0d", c, data, 5 + c - 2);
        end
      end
      if (c == 2) begin
        checks++;
        if (cur_id !== 4'hA) begin
          errors++;
          $display("FAIL single_id got %h want a", cur_id);
        end
      end
      if (c == 1) req[0] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int exp_d[8] = '{0, 0, 5, 6, 6, 6, 7, 8};
    logic [4*N-1:0] e;
    set_slot(0, 4'hB, 10'd5, 16'd4);
    rdy = '1;
    @(negedge clk_intf);
    req[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 2, 7, 8, 4'b0001);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL bp_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (data !== DW'(exp_d[c])) begin
          errors++;
          $display("FAIL bp_data c%0d got %0d want %0d", c, data, exp_d[c]);
        end
      end
      if (c == 1) req[0] = 1'b0;
      if (c == 3) rdy[0] = 1'b0;
      if (c == 5) rdy[0] = 1'b1;
    end
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 2, 3, 0, 2, 3};
    int n = 0;
    int g;
    rst = 1'b1;
    @(negedge clk_intf);
    rst = 1'b0;
    set_slot(0, 4'h1, 10'd400, 16'd1);
    set_slot(2, 4'h3, 10'd410, 16'd1);
    set_slot(3, 4'h4, 10'd420, 16'd1);
    rdy = '1;
    req = 4'b1101;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk_intf);
      checks++;
      if ($countones(ack) > 1 || $countones(vld) > 1 || $countones(in_prog) > 1 ||
          $countones(cmpl) > 1) begin
        errors++;
        $display("FAIL rr_onehot got ack=%b vld=%b ip=%b cmpl=%b", ack, vld, in_prog, cmpl);
      end
      for (int i = 0; i < N; i++) if (cmpl[i]) req[i] = 1'b1;
      if (ack != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (ack[i]) g = i;
        checks++;
        if (g != order[n]) begin
          errors++;
          $display("FAIL rr_grant #%0d got slot %0d want slot %0d", n, g, order[n]);
        end
        checks++;
        if (cur_id !== IW'(g + 1)) begin
          errors++;
          $display("FAIL rr_id #%0d got %h want %h", n, cur_id, g + 1);
        end
        req[g] = 1'b0;
        n++;
      end
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL rr_timeout got %0d grants want 6", n);
    end
    req = '0;
    repeat (8) @(negedge clk_intf);
  endtask

  task automatic test_boundary();
    int exp_d[4] = '{1022, 1023, 0, 1};
    logic [4*N-1:0] e;
    set_slot(1, 4'h5, 10'd1022, 16'd4);
    @(negedge clk_intf);
    req[1] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 2, 5, 6, 4'b0010);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL wrap_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (data !== DW'(exp_d[c-2])) begin
          errors++;
          $display("FAIL wrap_data c%0d got %0d want %0d", c, data, exp_d[c-2]);
        end
      end
      if (c == 1) req[1] = 1'b0;
    end
    set_slot(2, 4'h6, 10'd7, 16'd0);
    @(negedge clk_intf);
    req[2] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 1, 0, 2, 4'b0100);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL len0_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c == 1) req[2] = 1'b0;
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [4*N-1:0] e;
    bit seen = 1'b0;
    set_slot(0, 4'h2, 10'd100, 16'd8);
    rdy = '1;
    @(negedge clk_intf);
    req[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_intf);
      if (c == 1) req[0] = 1'b0;
      if (c == 3) begin
        checks++;
        if (vld !== 4'b0001 || data !== DW'(101)) begin
          errors++;
          $display("FAIL rst_pre got vld=%b data=%0d want vld=0001 data=101", vld, data);
        end
      end
    end
    @(negedge clk_intf);
    rst = 1'b1;
    #1;
    checks++;
    if ({ack, in_prog, vld, cmpl, data, cur_id} !== '0) begin
      errors++;
      $display("FAIL rst_async got ack=%b ip=%b vld=%b cmpl=%b want all 0", ack, in_prog, vld, cmpl);
    end
    @(negedge clk_intf);
    checks++;
    if ({ack, in_prog, vld, cmpl, data, cur_id} !== '0) begin
      errors++;
      $display("FAIL rst_hold got ack=%b ip=%b vld=%b cmpl=%b want all 0", ack, in_prog, vld, cmpl);
    end
    rst = 1'b0;
    set_slot(1, 4'h7, 10'd200, 16'd2);
    set_slot(3, 4'h8, 10'd0, 16'd0);
    req = 4'b1010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 2, 3, 4, 4'b0010);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL post_rst_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (data !== DW'(200 + c - 2)) begin
          errors++;
          $display("FAIL post_rst_data c%0d got %0d want %0d", c, data, 200 + c - 2);
        end
      end
      if (c == 1) req[1] = 1'b0;
    end
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_intf);
      if (ack[3]) begin
        seen = 1'b1;
        req[3] = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL post_rst_slot3 got no ack want ack[3]");
    end
    repeat (4) @(negedge clk_intf);
  endtask

  task automatic test_write_collision();
    logic [4*N-1:0] e;
    set_slot(0, 4'h9, 10'd300, 16'd3);
    rdy = '1;
    @(negedge clk_intf);
    req[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 2, 4, 5, 4'b0001);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL coll_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (data !== DW'(300 + c - 2)) begin
          errors++;
          $display("FAIL coll_data c%0d got %h want %0d", c, data, 300 + c - 2);
        end
      end
      if (c == 1) req[0] = 1'b0;
      if (c == 2) begin
        mem_wr_en = 1'b1; mem_wr_addr = 10'd301; mem_wr_data = NEW_WORD;
      end
      if (c == 3) mem_wr_en = 1'b0;
    end
    set_slot(0, 4'h9, 10'd301, 16'd1);
    @(negedge clk_intf);
    req[0] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_intf);
      e = ctrl_exp(c, 2, 2, 3, 4'b0001);
      checks++;
      if ({ack, vld, in_prog, cmpl} !== e) begin
        errors++;
        $display("FAIL newword_ctrl c%0d got %h want %h", c, {ack, vld, in_prog, cmpl}, e);
      end
      if (c == 2) begin
        checks++;
        if (data !== NEW_WORD) begin
          errors++;
          $display("FAIL newword_data got %h want %h", data[31:0], NEW_WORD[31:0]);
        end
      end
      if (c == 1) req[0] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_backpressure();
    test_round_robin();
    test_boundary();
    test_reset_mid_stream();
    test_write_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
